frame_capture_buffer: RTL

Ping-pong sample buffer that sits directly upstream of the Hann windowing stage in each analyzer channel. It collects audio samples from the receiver at the audio rate, one `2**b_fftp` frame per bank. When a frame is complete it hands the full bank to the window stage with a one-cycle `Start` pulse. It then serves samples to the window stage in ascending order on read strobes, while the other bank fills.

---
 rtl/frame_capture_buffer.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/frame_capture_buffer.sv
// Ping-pong capture buffer feeding the Hann window stage: fills one bank while the other is read out.
// Optional saturating dropped-frame counter on OvrCount when FCB_OVERRUN_CNT_EN is defined.
module frame_capture_buffer #(
  parameter int b_data = 16,
  parameter int b_fftp = 12,
  parameter int b_ovr  = 8
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [b_data-1:0] SampleIn,
  input  logic              SampleValid,
  input  logic              WinBusy,
  input  logic              RdEn,
  input  logic              RdDone,
  input  logic              OvrClr,
  output logic              Start,
  output logic [b_data-1:0] RdData,
  output logic              Overrun
`ifdef FCB_OVERRUN_CNT_EN
  ,
  output logic [b_ovr-1:0]  OvrCount
`endif
);

  localparam int DEPTH = 2 * (2 ** b_fftp);
  localparam logic [b_fftp-1:0] PTR_ONE  = {{(b_fftp-1){1'b0}}, 1'b1};
  localparam logic [b_fftp-1:0] PTR_LAST = {b_fftp{1'b1}};

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_PEND = 2'd1,
    R_READ = 2'd2
  } rdState_t;

  logic [b_data-1:0] mem [0:DEPTH-1];

  rdState_t          state_r;
  rdState_t          stateNext_s;
  logic              wBank_r;
  logic              rBank_r;
  logic [b_fftp-1:0] wPtr_r;
  logic [b_fftp-1:0] rPtr_r;
  logic [b_data-1:0] rdData_r;
  logic              overrun_r;
  logic              frameDone_s;
  logic              handOver_s;
  logic              dropFrame_s;
  logic              startPulse_s;
  logic              rdFire_s;

  // A completed frame is only accepted when no frame is held, or the held one is released this cycle
  assign frameDone_s = SampleValid && (wPtr_r == PTR_LAST);
  assign handOver_s  = frameDone_s &&
                       ((state_r == R_IDLE) || ((state_r == R_READ) && RdDone));
  assign dropFrame_s = frameDone_s && !handOver_s;
  assign rdFire_s    = (state_r == R_READ) && RdEn;

  // Read FSM next state and the Start pulse
  always_comb begin
    stateNext_s  = state_r;
    startPulse_s = 1'b0;
    case (state_r)
      R_IDLE: begin
        if (handOver_s) stateNext_s = R_PEND;
        else            stateNext_s = R_IDLE;
      end
      R_PEND: begin
        if (!WinBusy) begin
          startPulse_s = 1'b1;
          stateNext_s  = R_READ;
        end else begin
          stateNext_s  = R_PEND;
        end
      end
      R_READ: begin
        if (handOver_s)  stateNext_s = R_PEND;
        else if (RdDone) stateNext_s = R_IDLE;
        else             stateNext_s = R_READ;
      end
      default: stateNext_s = R_IDLE;
    endcase
  end

  // Sample storage; contents are deliberately left unreset
  always_ff @(posedge Clock) begin
    if (SampleValid) mem[{wBank_r, wPtr_r}] <= SampleIn;
  end

  // Bank/pointer bookkeeping, FSM state and registered read data
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_r  <= R_IDLE;
      wBank_r  <= 1'b0;
      rBank_r  <= 1'b0;
      wPtr_r   <= {b_fftp{1'b0}};
      rPtr_r   <= {b_fftp{1'b0}};
      rdData_r <= {b_data{1'b0}};
    end else begin
      state_r <= stateNext_s;
      if (SampleValid) wPtr_r <= wPtr_r + PTR_ONE;
      if (handOver_s) begin
        rBank_r <= wBank_r;
        wBank_r <= ~wBank_r;
      end
      if (startPulse_s)  rPtr_r <= {b_fftp{1'b0}};
      else if (rdFire_s) rPtr_r <= rPtr_r + PTR_ONE;
      if (rdFire_s) rdData_r <= mem[{rBank_r, rPtr_r}];
    end
  end

  // Sticky overrun flag; a drop outranks a coincident clear
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset)            overrun_r <= 1'b0;
    else if (dropFrame_s) overrun_r <= 1'b1;
    else if (OvrClr)      overrun_r <= 1'b0;
  end

`ifdef FCB_OVERRUN_CNT_EN
  localparam logic [b_ovr-1:0] CNT_ONE = {{(b_ovr-1){1'b0}}, 1'b1};
  localparam logic [b_ovr-1:0] CNT_MAX = {b_ovr{1'b1}};
  logic [b_ovr-1:0] ovrCount_r;

  // Saturating dropped-frame counter
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      ovrCount_r <= {b_ovr{1'b0}};
    end else if (dropFrame_s) begin
      if (OvrClr)                    ovrCount_r <= CNT_ONE;
      else if (ovrCount_r != CNT_MAX) ovrCount_r <= ovrCount_r + CNT_ONE;
    end else if (OvrClr) begin
      ovrCount_r <= {b_ovr{1'b0}};
    end
  end

  assign OvrCount = ovrCount_r;
`endif

  assign Start   = startPulse_s;
  assign RdData  = rdData_r;
  assign Overrun = overrun_r;

endmodule
